// File: rtl/icache_fill_responder_if.sv
// Instruction-fill bus between per-CPU icache requesters, the responder and the instruction RAM port.
// slave = responder view; master = environment (CPUs, RAM, data-side arbiter) view.
interface icache_fill_responder_if #(
  parameter int CPUS       = 2,
  parameter int RAMSTATE_W = 2
);
  logic [CPUS-1:0]       iREN;
  logic [CPUS*32-1:0]    iaddr;
  logic [CPUS-1:0]       iwait;
  logic [CPUS*32-1:0]    iload;
  logic                  dbusy;
  logic                  ramREN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramload;
  logic [RAMSTATE_W-1:0] ramstate;
  logic                  ierr;

  modport slave (
    input  iREN, iaddr, dbusy, ramload, ramstate,
    output iwait, iload, ramREN, ramaddr, ierr
  );

  modport master (
    output iREN, iaddr, dbusy, ramload, ramstate,
    input  iwait, iload, ramREN, ramaddr, ierr
  );
endinterface

// File: rtl/icache_fill_responder.sv
// Round-robin responder for icache fill requests: one instruction RAM read at a time,
// answered with a single-cycle iwait-low pulse to the granted CPU.
module icache_fill_responder #(
  parameter int CPUS       = 2,
  parameter int RAMSTATE_W = 2
) (
  input logic                    CLK,
  input logic                    RST,
  icache_fill_responder_if.slave bus
);
  localparam int IDW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  typedef enum logic [RAMSTATE_W-1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_t;

  state_t              state_q, state_n;
  logic [IDW-1:0]      ptr_q, ptr_n;
  logic [IDW-1:0]      gnt_q, gnt_n;
  logic [31:0]         addr_q, addr_n;
  logic [31:0]         data_q, data_n;
  logic                ierr_q, ierr_n;

  logic [CPUS-1:0][31:0] addr_v;
  logic [CPUS-1:0][31:0] load_c;
  logic [CPUS-1:0]       wait_c;
  logic                  ren_c;
  logic                  found;
  logic [IDW-1:0]        pick;
  logic [IDW-1:0]        cand;

  assign addr_v      = bus.iaddr;
  assign bus.iload   = load_c;
  assign bus.iwait   = wait_c;
  assign bus.ramREN  = ren_c;
  assign bus.ramaddr = addr_q;
  assign bus.ierr    = ierr_q;

  // First requester at or after the pointer, wrapping past CPUS-1.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int unsigned i = 0; i < CPUS; i++) begin
      cand = IDW'((32'(ptr_q) + i) % CPUS);
      if (!found && bus.iREN[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    gnt_n   = gnt_q;
    addr_n  = addr_q;
    data_n  = data_q;
    ierr_n  = ierr_q;
    wait_c  = '1;
    load_c  = '0;
    ren_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.dbusy && found) begin
          gnt_n   = pick;
          addr_n  = {addr_v[pick][31:2], 2'b00};
          state_n = FETCH;
        end
      end
      FETCH: begin
        ren_c = 1'b1;
        case (bus.ramstate)
          RAM_ACCESS: begin
            data_n  = bus.ramload;
            state_n = DONE;
          end
          RAM_ERROR: begin
            ierr_n  = 1'b1;
            state_n = IDLE;
          end
          default: state_n = FETCH;
        endcase
      end
      DONE: begin
        // Only answer if the requester still wants this exact word; otherwise drop it.
        if (bus.iREN[gnt_q] && (addr_v[gnt_q][31:2] == addr_q[31:2])) begin
          wait_c[gnt_q] = 1'b0;
          load_c[gnt_q] = data_q;
        end
        ptr_n   = (gnt_q == IDW'(CPUS - 1)) ? '0 : gnt_q + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ierr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      gnt_q   <= gnt_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      ierr_q  <= ierr_n;
    end
  end
endmodule

// File: tb/tb_icache_fill_responder.sv
// Bench for icache_fill_responder: directed vector table, a dropped-request sequence,
// then random CPU/RAM/dbusy traffic checked against a transaction-level model.
module tb_icache_fill_responder;
  localparam logic [1:0] FR = 2'd0, BS = 2'd1, AC = 2'd2, ER = 2'd3;
  localparam int LIMIT = 300;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  icache_fill_responder_if #(.CPUS(2), .RAMSTATE_W(2)) bus ();
  icache_fill_responder #(.CPUS(2), .RAMSTATE_W(2)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic        rst;
    logic [1:0]  iren;
    logic [31:0] a0, a1;
    logic        db;
    logic [1:0]  rs;
    logic [31:0] rd;
    logic        ren;
    logic        chka;
    logic [31:0] raddr;
    logic [1:0]  iw;
    logic [31:0] l0, l1;
    logic        ie;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t v(input logic rst, input logic [1:0] iren, input logic [31:0] a0, a1,
                             input logic db, input logic [1:0] rs, input logic [31:0] rd,
                             input logic ren, chka, input logic [31:0] raddr, input logic [1:0] iw,
                             input logic [31:0] l0, l1, input logic ie);
    vec_t r;
    r.rst = rst; r.iren = iren; r.a0 = a0; r.a1 = a1; r.db = db; r.rs = rs; r.rd = rd;
    r.ren = ren; r.chka = chka; r.raddr = raddr; r.iw = iw; r.l0 = l0; r.l1 = l1; r.ie = ie;
    return r;
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5C3_0F96;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] iren, input logic [31:0] a0, a1, input logic db,
                       input logic [1:0] rs, input logic [31:0] rd);
    bus.iREN = iren; bus.iaddr = {a1, a0}; bus.dbusy = db; bus.ramstate = rs; bus.ramload = rd;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(2'b00, '0, '0, 1'b0, FR, '0);
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Random-phase model state
  logic [31:0] addr_m [2];
  logic        pend [2];
  int          age [2];
  int          ptr_m;
  logic        err_m;
  logic        ren_prev, db_prev;
  logic [1:0]  iren_prev;

  initial begin
    // reset / zero-wait fetch
    tbl.push_back(v(0,2'b01,32'h40,0,0,FR,0,          0,1,32'h0, 2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h40,0,0,AC,32'h20020001,1,1,32'h40,2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h40,0,0,FR,0,          0,0,0,     2'b10,32'h20020001,0,0));
    tbl.push_back(v(0,2'b00,32'h40,0,0,FR,0,          0,0,0,     2'b11,0,0,0));
    // four BUSY wait states
    tbl.push_back(v(0,2'b01,32'h44,0,0,FR,0,          0,0,0,     2'b11,0,0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0,2'b01,32'h44,0,0,BS,0,        1,1,32'h44,2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h44,0,0,AC,32'h12345678,1,1,32'h44,2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h44,0,0,FR,0,          0,0,0,     2'b10,32'h12345678,0,0));
    tbl.push_back(v(0,2'b00,32'h44,0,0,FR,0,          0,0,0,     2'b11,0,0,0));
    // contention, pointer at 1: CPU1, CPU0, CPU1
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,FR,0,   0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,AC,32'hB200,1,1,32'h200,2'b11,0,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,FR,0,   0,0,0,     2'b01,0,32'hB200,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,FR,0,   0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,AC,32'hA100,1,1,32'h100,2'b11,0,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,FR,0,   0,0,0,     2'b10,32'hA100,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,FR,0,   0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,AC,32'hB200,1,1,32'h200,2'b11,0,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,FR,0,   0,0,0,     2'b01,0,32'hB200,0));
    tbl.push_back(v(0,2'b00,32'h100,32'h200,0,FR,0,   0,0,0,     2'b11,0,0,0));
    // dbusy blocks the grant for 6 cycles; raising it mid-fetch does not abort
    for (int k = 0; k < 6; k++)
      tbl.push_back(v(0,2'b10,0,32'h300,1,FR,0,       0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b10,0,32'h300,0,FR,0,         0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b10,0,32'h300,1,BS,0,         1,1,32'h300,2'b11,0,0,0));
    tbl.push_back(v(0,2'b10,0,32'h300,1,AC,32'hC300,  1,1,32'h300,2'b11,0,0,0));
    tbl.push_back(v(0,2'b10,0,32'h300,1,FR,0,         0,0,0,     2'b01,0,32'hC300,0));
    tbl.push_back(v(0,2'b00,0,32'h300,0,FR,0,         0,0,0,     2'b11,0,0,0));
    // address changed mid-fetch: discard, then refetch the new (unaligned) address
    tbl.push_back(v(0,2'b01,32'h40,0,0,FR,0,          0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h83,0,0,BS,0,          1,1,32'h40,2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h83,0,0,AC,32'h4040,   1,1,32'h40,2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h83,0,0,FR,0,          0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h83,0,0,FR,0,          0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h83,0,0,AC,32'h8080,   1,1,32'h80,2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h83,0,0,FR,0,          0,0,0,     2'b10,32'h8080,0,0));
    tbl.push_back(v(0,2'b00,32'h83,0,0,FR,0,          0,0,0,     2'b11,0,0,0));
    // RAM error: sticky ierr and retry; then reset mid-fetch
    tbl.push_back(v(0,2'b01,32'h50,0,0,FR,0,          0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h50,0,0,ER,0,          1,1,32'h50,2'b11,0,0,0));
    tbl.push_back(v(0,2'b01,32'h50,0,0,FR,0,          0,0,0,     2'b11,0,0,1));
    tbl.push_back(v(0,2'b01,32'h50,0,0,AC,32'h5050,   1,1,32'h50,2'b11,0,0,1));
    tbl.push_back(v(0,2'b01,32'h50,0,0,FR,0,          0,0,0,     2'b10,32'h5050,0,1));
    tbl.push_back(v(0,2'b01,32'h60,0,0,FR,0,          0,0,0,     2'b11,0,0,1));
    tbl.push_back(v(0,2'b01,32'h60,0,0,BS,0,          1,1,32'h60,2'b11,0,0,1));
    tbl.push_back(v(1,2'b01,32'h60,0,0,BS,0,          1,1,32'h60,2'b11,0,0,1));
    tbl.push_back(v(0,2'b00,32'h60,0,0,FR,0,          0,1,32'h0, 2'b11,0,0,0));
    // pointer back at 0 after reset
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,FR,0,   0,0,0,     2'b11,0,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,AC,32'hA100,1,1,32'h100,2'b11,0,0,0));
    tbl.push_back(v(0,2'b11,32'h100,32'h200,0,FR,0,   0,0,0,     2'b10,32'hA100,0,0));
    tbl.push_back(v(0,2'b00,0,0,0,FR,0,               0,0,0,     2'b11,0,0,0));

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      RST = tbl[k].rst;
      drive(tbl[k].iren, tbl[k].a0, tbl[k].a1, tbl[k].db, tbl[k].rs, tbl[k].rd);
      #2;
      chk($sformatf("row%0d_ramREN", k), 64'(bus.ramREN), 64'(tbl[k].ren));
      chk($sformatf("row%0d_iwait", k), 64'(bus.iwait), 64'(tbl[k].iw));
      chk($sformatf("row%0d_iload", k), bus.iload, {tbl[k].l1, tbl[k].l0});
      chk($sformatf("row%0d_ierr", k), 64'(bus.ierr), 64'(tbl[k].ie));
      if (tbl[k].chka)
        chk($sformatf("row%0d_ramaddr", k), 64'(bus.ramaddr), 64'(tbl[k].raddr));
      tick();
    end

    // CPU1 drops iREN mid-fetch: response discarded, IDLE revisited, then served on re-request
    drive(2'b10, 0, 32'h700, 0, FR, 0); #2; tick();
    drive(2'b00, 0, 32'h700, 0, AC, 32'h7777); #2;
    chk("drop_fetch_ramREN", 64'(bus.ramREN), 64'd1);
    chk("drop_fetch_ramaddr", 64'(bus.ramaddr), 64'h700);
    tick();
    drive(2'b00, 0, 32'h700, 0, FR, 0); #2;
    chk("drop_done_iwait", 64'(bus.iwait), 64'h3);
    chk("drop_done_iload", bus.iload, 64'h0);
    tick();
    drive(2'b10, 0, 32'h700, 0, FR, 0); #2;
    chk("drop_idle_ramREN", 64'(bus.ramREN), 64'd0);
    tick();
    drive(2'b10, 0, 32'h700, 0, AC, 32'h7777); #2;
    chk("refetch_ramREN", 64'(bus.ramREN), 64'd1);
    tick();
    drive(2'b10, 0, 32'h700, 0, FR, 0); #2;
    chk("refetch_iwait", 64'(bus.iwait), 64'h1);
    chk("refetch_iload1", 64'(bus.iload[63:32]), 64'h7777);
    tick();

    // Random traffic against a transaction-level model
    do_reset();
    ptr_m = 0; err_m = 1'b0; ren_prev = 1'b0; db_prev = 1'b0; iren_prev = 2'b00;
    for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; age[i] = 0; addr_m[i] = '0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int nlow;
      logic [1:0] rs;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          age[i] = 0;
          addr_m[i] = (32'(i) << 24) | ($urandom & 32'h00FF_FFFF);
        end
        bus.iREN[i] = pend[i];
        bus.iaddr[i*32 +: 32] = addr_m[i];
      end
      bus.dbusy = ($urandom_range(0, 3) == 0);
      if (bus.ramREN) begin
        int r;
        r = $urandom_range(0, 15);
        rs = (r == 0) ? ER : (r < 6) ? BS : AC;
        bus.ramload = mem(bus.ramaddr);
      end else begin
        rs = 2'($urandom_range(0, 3));
        bus.ramload = $urandom;
      end
      bus.ramstate = rs;
      #2;
      nlow = 0;
      for (int i = 0; i < 2; i++) begin
        if (!bus.iwait[i]) begin
          nlow++;
          chk("rnd_pulse_needs_req", 64'(bus.iREN[i]), 64'd1);
          chk("rnd_iload", 64'(bus.iload[i*32 +: 32]), 64'(mem(addr_m[i])));
          chk("rnd_latency_bound", 64'(age[i] <= LIMIT), 64'd1);
          pend[i] = 1'b0;
          ptr_m = (i + 1) % 2;
        end else begin
          chk("rnd_iload_idle", 64'(bus.iload[i*32 +: 32]), 64'h0);
        end
      end
      chk("rnd_one_pulse", 64'(nlow <= 1), 64'd1);
      chk("rnd_ierr", 64'(bus.ierr), 64'(err_m));
      if (bus.ramREN && !ren_prev) begin
        int w;
        w = -1;
        for (int j = 0; j < 2; j++)
          if (w < 0 && iren_prev[(ptr_m + j) % 2]) w = (ptr_m + j) % 2;
        chk("rnd_grant_dbusy", 64'(db_prev), 64'd0);
        chk("rnd_grant_has_req", 64'(w >= 0), 64'd1);
        if (w >= 0)
          chk("rnd_grant_addr", 64'(bus.ramaddr), 64'({addr_m[w][31:2], 2'b00}));
      end
      if (bus.ramREN && rs == ER) err_m = 1'b1;
      ren_prev  = bus.ramREN;
      db_prev   = bus.dbusy;
      iren_prev = bus.iREN;
      for (int i = 0; i < 2; i++) if (pend[i]) age[i]++;
      tick();
    end
    for (int i = 0; i < 2; i++)
      chk("rnd_final_wait_bound", 64'(age[i] <= LIMIT), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_fill_responder.md
Name: icache_fill_responder

Overview:
- Memory-side responder for instruction-cache fill requests; the other end of the iREN/iaddr/iwait/iload protocol that each CPU's icache drives.
- Arbitrates round-robin among CPUS icache requesters and issues one RAM read at a time on a dedicated instruction RAM port.
- Returns the fetched word with a single-cycle iwait-low pulse to the granted CPU.
- Sits inside the memory controller, alongside the data-side path, which has priority via dbusy.

Parameters:
CPUS, 2, number of icache requesters
RAMSTATE_W, 2, width of ramstate (FREE=0, BUSY=1, ACCESS=2, ERROR=3)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
iREN  in  CPUS  per-CPU instruction read request, held high until served
iaddr  in  CPUS*32  per-CPU word address, bits [1:0] ignored
iwait  out  CPUS  per-CPU wait; low for exactly one cycle when iload is valid
iload  out  CPUS*32  per-CPU returned instruction word
dbusy  in  1  data side owns RAM; no new instruction grant while high
ramREN  out  1  RAM read enable
ramaddr  out  32  RAM address
ramload  in  32  RAM read data, valid when ramstate==ACCESS
ramstate  in  2  RAM status
ierr  out  1  sticky: RAM returned ERROR on an instruction fetch

Behaviour:
- Reset (RST high at a CLK edge, any state):
  - FSM to IDLE; round-robin pointer to 0.
  - iwait all 1; iload all 0; ramREN 0; ramaddr 0; ierr 0.
  - Any in-flight fetch is abandoned with no response.
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - If dbusy is low and any iREN is high, grant the first requesting CPU at or after the pointer, scanning upward and wrapping at CPUS-1 to 0.
  - Latch the grant id and {iaddr[31:2],2'b00}, then go to FETCH.
  - Otherwise stay in IDLE.
  - ramREN is 0 in IDLE.
- FETCH:
  - ramREN=1; ramaddr=latched address.
  - ramstate FREE or BUSY: stay in FETCH.
  - ramstate ACCESS: register ramload, go to DONE.
  - ramstate ERROR: set ierr, go to IDLE with no response; the requester stays pending and is re-arbitrated.
  - dbusy rising during FETCH does not preempt; the fetch completes.
- DONE (one cycle):
  - ramREN=0.
  - If the granted CPU still has iREN high and iaddr[31:2] equals the latched address, drive iwait[g]=0 and iload[g]=registered word.
  - Otherwise the response is discarded and iwait stays 1 (requester dropped or changed its request mid-fetch).
  - Either way, set the pointer to (g+1) mod CPUS and go to IDLE.
- Non-granted CPUs always see iwait=1 and iload=0. iload is 0 for every CPU whenever its iwait is 1.
- Latency: the grant edge, then N cycles in FETCH until ACCESS, then DONE. With a zero-wait RAM (ACCESS on the first FETCH cycle), iwait goes low in the third cycle after iREN is sampled high.
- Back-to-back: after DONE, IDLE is revisited for one cycle before the next grant. Maximum throughput is one word per 3 cycles with a zero-wait RAM.
- Simultaneous requests: the pointer decides the winner. Two continuously requesting CPUs alternate strictly.
- ierr clears only on reset.

Test Plan:
- Single fetch, zero-wait RAM: reset, CPU0 iREN=1, iaddr=0x0000_0040, RAM returns ACCESS with 0x2002_0001 on the first FETCH cycle -> ramaddr=0x40 during FETCH; iwait[0]=0 and iload[0]=0x2002_0001 for exactly one cycle, 3 cycles after the request; iwait[1] stays 1.
- Wait states: RAM holds BUSY for 4 cycles, then ACCESS -> ramREN high for 5 cycles; response in DONE; no iwait glitch during BUSY.
- Contention: CPU0 and CPU1 both request continuously from reset, addresses 0x100 and 0x200 -> grants go CPU0, CPU1, CPU0, CPU1; each response carries its own data; pointer alternates.
- dbusy blocking: dbusy=1 for 6 cycles with CPU1 requesting -> ramREN stays 0; grant occurs on the first IDLE cycle with dbusy=0. Raising dbusy during FETCH does not abort the fetch.
- Abandoned request: CPU0 changes iaddr 0x40 to 0x80 during FETCH -> DONE drives no pulse; next arbitration fetches 0x80 and returns its word.
- Error and reset: ramstate=ERROR in FETCH -> ierr=1 and the request retries. Asserting RST mid-FETCH -> next cycle ramREN=0, all iwait=1, ierr=0, FSM in IDLE.
